// File: rtl/fa_serial_pkg.sv
// Shared types and defaults for the bit-serial full-adder sequencer.
package fa_serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_SETTLE_CYC = 4;

    // Width of a counter that must hold values 0..settle.
    function automatic int cnt_width(input int settle);
        return $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/fa_settle_cnt.sv
// Loadable down-counter with zero flag; paces the adder cell settle window.
module fa_settle_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load has priority over decrement; reset clears the count.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec)
            cnt <= cnt - CNT_W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/fa_serial_seq.sv
// Bit-serial add/subtract sequencer driving one shared full-adder cell, LSB first.
module fa_serial_seq
    import fa_serial_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int CNT_W = cnt_width(SETTLE_CYC);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             accept;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;

    assign accept = in_valid & in_ready;

    // Next-bit bookkeeping and settle-counter controls.
    always_comb begin
        sum_next      = sum_reg;
        sum_next[idx] = fa_sum;
        idx_nxt       = idx + IDX_W'(1);
        cnt_load      = accept || ((state == SAMPLE) && (idx != LAST));
        cnt_dec       = (state == DRIVE) && !cnt_zero;
    end

    fa_settle_cnt #(
        .CNT_W (CNT_W)
    ) u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (RELOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Main FSM with registered handshake, result and cell drive outputs.
    // Cell inputs for the next bit are registered on the same edge that
    // leaves SAMPLE, so the settle window starts counting immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            sum_reg   <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            busy      <= 1'b0;
            fa_a      <= 1'b0;
            fa_b      <= 1'b0;
            fa_cin    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a     <= in_a;
                        op_b     <= in_sub ? ~in_b : in_b;
                        carry    <= in_sub ? 1'b1 : in_cin;
                        idx      <= '0;
                        fa_a     <= in_a[0];
                        fa_b     <= in_b[0] ^ in_sub;
                        fa_cin   <= in_sub ? 1'b1 : in_cin;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt_zero)
                        state <= SAMPLE;
                end
                SAMPLE: begin
                    sum_reg <= sum_next;
                    carry   <= fa_cout;
                    if (idx == LAST) begin
                        out_valid <= 1'b1;
                        out_sum   <= sum_next;
                        out_cout  <= fa_cout;
                        fa_a      <= 1'b0;
                        fa_b      <= 1'b0;
                        fa_cin    <= 1'b0;
                        state     <= DONE;
                    end else begin
                        idx    <= idx_nxt;
                        fa_a   <= op_a[idx_nxt];
                        fa_b   <= op_b[idx_nxt];
                        fa_cin <= fa_cout;
                        state  <= DRIVE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fa_serial_seq.sv
// Directed self-checking bench for fa_serial_seq.
module tb_fa_serial_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // Main instance: WIDTH=8, SETTLE_CYC=4, cell model with 3-cycle delay
    logic       in_valid = 1'b0, in_ready, in_cin = 1'b0, in_sub = 1'b0;
    logic [7:0] in_a = '0, in_b = '0, out_sum;
    logic       out_valid, out_ready = 1'b0, out_cout, busy;
    logic       fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic [1:0] d1 = '0, d2 = '0, d3 = '0;

    // Second instance: SETTLE_CYC=1, zero-delay cell model
    logic       in_valid1 = 1'b0, in_ready1, in_cin1 = 1'b0, in_sub1 = 1'b0;
    logic [7:0] in_a1 = '0, in_b1 = '0, out_sum1;
    logic       out_valid1, out_ready1 = 1'b0, out_cout1, busy1;
    logic       fa_a1, fa_b1, fa_cin1, fa_sum1, fa_cout1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fa_serial_seq #(.WIDTH(8), .SETTLE_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_sum(fa_sum), .fa_cout(fa_cout)
    );

    fa_serial_seq #(.WIDTH(8), .SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1), .in_sub(in_sub1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_cout(out_cout1), .busy(busy1),
        .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1),
        .fa_sum(fa_sum1), .fa_cout(fa_cout1)
    );

    // Full-adder cell whose outputs follow its inputs three cycles later
    always @(posedge clk) begin
        d1 <= {fa_a ^ fa_b ^ fa_cin, (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin)};
        d2 <= d1;
        d3 <= d2;
    end
    assign fa_sum  = d3[1];
    assign fa_cout = d3[0];

    assign fa_sum1  = fa_a1 ^ fa_b1 ^ fa_cin1;
    assign fa_cout1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request to the main instance and wait (bounded) for its result.
    // Leaves out_valid asserted; fa_a is captured once per bit for sequence checks.
    task automatic start_and_wait(input logic [7:0] a, input logic [7:0] b,
                                  input logic cin, input logic sub,
                                  output int lat, output logic [7:0] fa_seq);
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        lat = 0;
        fa_seq = '0;
        while (lat < 200) begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if ((lat % 5) == 1 && lat <= 36) fa_seq[(lat - 1) / 5] = fa_a;
            if (out_valid) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub,
                          input logic [7:0] exp_sum, input logic exp_cout);
        int         lat;
        logic [7:0] seq;
        start_and_wait(a, b, cin, sub, lat, seq);
        chk({tag, "_latency"}, lat, 32'd41);
        chk({tag, "_sum"}, {24'd0, out_sum}, {24'd0, exp_sum});
        chk({tag, "_cout"}, {31'd0, out_cout}, {31'd0, exp_cout});
        chk({tag, "_fa_seq"}, {24'd0, seq}, {24'd0, a ^ (sub ? 8'hFF : 8'h00) ^ (sub ? 8'hFF : 8'h00)});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_sum_held"}, {24'd0, out_sum}, {24'd0, exp_sum});
    endtask

    initial begin
        int         lat;
        logic [7:0] seq;
        logic [7:0] held_sum;
        logic       held_cout;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_sum", {24'd0, out_sum}, 32'd0);
        chk("rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
        rst = 1'b0;

        // fa_a across bits for A=0x05 is 1,0,1,0,0,0,0,0 -> 0x05 LSB first
        start_and_wait(8'h05, 8'h03, 1'b0, 1'b0, lat, seq);
        chk("add5_3_latency", lat, 32'd41);
        chk("add5_3_sum", {24'd0, out_sum}, 32'h08);
        chk("add5_3_cout", {31'd0, out_cout}, 32'd0);
        chk("add5_3_fa_a_seq", {24'd0, seq}, 32'h05);
        chk("add5_3_busy", {31'd0, busy}, 32'd1);
        chk("done_fa_zero", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);

        // Backpressure: result must hold and no new request may start
        held_sum = out_sum;
        held_cout = out_cout;
        in_a = 8'h11; in_b = 8'h22; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_sum", {24'd0, out_sum}, 32'h08);
            chk("hold_cout", {31'd0, out_cout}, 32'd0);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_busy", {31'd0, busy}, 32'd0);
        chk("release_valid", {31'd0, out_valid}, 32'd0);
        chk("release_sum_held", {24'd0, out_sum}, {24'd0, held_sum});
        chk("release_cout_held", {31'd0, out_cout}, {31'd0, held_cout});

        run_op("addFF_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        run_op("add7F_00c", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0);
        run_op("sub10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        run_op("sub01_02", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);

        // Reset in the middle of an operation
        @(negedge clk);
        in_a = 8'h33; in_b = 8'h11; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        chk("midop_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
        chk("midrst_sum", {24'd0, out_sum}, 32'd0);
        run_op("add0A_05", 8'h0A, 8'h05, 1'b0, 1'b0, 8'h0F, 1'b0);

        // SETTLE_CYC=1 instance with zero-delay cell
        @(negedge clk);
        in_a1 = 8'hAA; in_b1 = 8'h55; in_cin1 = 1'b0; in_sub1 = 1'b0; in_valid1 = 1'b1;
        chk("s1_in_ready", {31'd0, in_ready1}, 32'd1);
        @(posedge clk);
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            in_valid1 = 1'b0;
            lat++;
            if (out_valid1) break;
        end
        chk("s1_latency", lat, 32'd17);
        chk("s1_sum", {24'd0, out_sum1}, 32'hFF);
        chk("s1_cout", {31'd0, out_cout1}, 32'd0);
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        chk("s1_idle_ready", {31'd0, in_ready1}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fa_serial_seq.md
Name: fa_serial_seq

Overview:
- Bit-serial sequencer that time-multiplexes one full-adder cell (fa_RC-class, RC-delay modelled) to add or subtract two WIDTH-bit operands, LSB first.
- Per bit: drives the cell's A/B/Cin, waits SETTLE_CYC cycles for the cell to settle, then samples Sum/Cout. The sampled Cout becomes the carry for the next bit.
- Sits between neuron accumulation logic (requester) and the single shared adder cell. Valid/ready on both request and result sides.

Parameters:
- WIDTH, 8, operand and result width in bits; WIDTH >= 1.
- SETTLE_CYC, 4, cycles the cell inputs are held before sampling; SETTLE_CYC >= 1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in (add mode only).
- in_sub  in  1  1 = compute A - B.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_sum  out  WIDTH  result.
- out_cout  out  1  final carry (borrow-not in sub mode).
- busy  out  1  high in any non-IDLE state.
- fa_a, fa_b, fa_cin  out  1 each  registered drives to the adder cell.
- fa_sum, fa_cout  in  1 each  adder cell outputs.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state = IDLE; all registers 0.
  - in_ready = 1; out_valid = 0; out_sum = 0; out_cout = 0; busy = 0; fa_a/fa_b/fa_cin = 0.
- Request latch (on acceptance):
  - op_a = in_a; op_b = in_sub ? ~in_b : in_b; carry = in_sub ? 1 : in_cin; bit index idx = 0.
- FSM:
  - IDLE: in_ready = 1. On accept → DRIVE, settle counter = SETTLE_CYC-1.
  - DRIVE: fa_a = op_a[idx], fa_b = op_b[idx], fa_cin = carry. Counter decrements each cycle; at 0 → SAMPLE.
  - SAMPLE: fa_* are held. Capture sum_reg[idx] = fa_sum and carry = fa_cout.
    - If idx == WIDTH-1 → DONE.
    - Else idx++, counter reloads SETTLE_CYC-1 → DRIVE.
  - DONE: out_valid = 1; out_sum = sum_reg; out_cout = carry; fa_* = 0. On out_ready → IDLE.
- Latency: acceptance edge at cycle 0; out_valid first high in cycle WIDTH*(SETTLE_CYC+1)+1. With defaults this is cycle 41.
- in_ready is 0 outside IDLE. in_valid is ignored there and no request is queued.
- out_sum and out_cout stay stable while out_valid=1 and out_ready=0.
- out_sum is updated only on entry to DONE. It holds the last result through IDLE until the next DONE.
- fa_sum/fa_cout are sampled only in SAMPLE. They are treated as settled and synchronous to clk; there is no synchronizer.
- Sub mode: out_cout = 1 means no borrow (A >= B unsigned).
- Reset mid-operation: aborts the operation with no result. Every output takes its reset value on the next cycle.
- WIDTH=1: a single DRIVE/SAMPLE pass, then DONE.

Decomposition:
- Package fa_serial_pkg holds:
  - state enum: IDLE, DRIVE, SAMPLE, DONE;
  - default WIDTH and SETTLE_CYC constants;
  - localparam function for counter width, $clog2(SETTLE_CYC+1).
- Sub-module fa_settle_cnt: loadable down-counter with zero flag, used for the settle timing.
- Bit index, operand/result registers and FSM stay in the top module.

Test Plan:
All cases use WIDTH=8, SETTLE_CYC=4, and a behavioural FA model whose outputs change 3 cycles after its inputs.
- Add 0x05+0x03, cin=0 → out_valid at cycle 41, out_sum=0x08, out_cout=0. fa_a sequence across bits is 1,0,1,0,0,0,0,0.
- Add 0xFF+0x01, cin=0 → out_sum=0x00, out_cout=1. Add 0x7F+0x00, cin=1 → 0x80, cout=0.
- Sub 0x10-0x01 → 0x0F, cout=1. Sub 0x01-0x02 → 0xFF, cout=0.
- Hold out_ready=0 for 10 cycles after out_valid, with in_valid=1 and new operands applied:
  - out_sum/out_cout stay constant; in_ready=0; fa_*=0; no new operation starts.
  - Raising out_ready gives IDLE with in_ready=1 on the next cycle.
- Assert rst at cycle 20 of an operation → next cycle: busy=0, in_ready=1, out_valid=0, fa_*=0. A following 0x0A+0x05 gives 0x0F at cycle 41 from its own acceptance.
- SETTLE_CYC=1 with a zero-delay FA model: 0xAA+0x55 → out_sum=0xFF, cout=0, out_valid at cycle 17.
